// File: rtl/tty_char_writer.sv
// Character-write front end of the VGA text console: turns CPU byte writes into
// video-RAM writes, tracks the cursor and performs line / full-screen blank fills.
module tty_char_writer #(
  parameter int         COLS       = 32,
  parameter int         ROWS       = 30,
  parameter int         ADDR_W     = 10,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              clk_50mhz,
  input  logic              rst_n,
  input  logic [31:0]       bus_data,
  input  logic              mem_write,
  output logic              vm_we,
  output logic [ADDR_W-1:0] vm_addr,
  output logic [7:0]        vm_din,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy,
  output logic              overflow
);

  localparam int CW = $clog2(COLS);
  localparam int RW = ADDR_W - CW;
  localparam logic [CW-1:0]     LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              pend_vld_q, pend_vld_d;
  logic [7:0]        pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              mw_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;

  logic              wr_event;
  logic [7:0]        chr;
  logic              adv_row;
  logic              unused_bus_bits;

  assign wr_event        = mem_write & ~mw_q;
  assign unused_bus_bits = ^bus_data[31:8];

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    fill_d     = fill_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    adv_row    = 1'b0;
    // A buffered byte always goes ahead of a fresh event so byte order is preserved.
    chr        = pend_vld_q ? pend_q : bus_data[7:0];

    if (state_q != IDLE && wr_event) begin
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = bus_data[7:0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          pend_vld_d = wr_event;
          if (wr_event) pend_d = bus_data[7:0];
        end
        if (pend_vld_q || wr_event) begin
          if (chr >= 8'h20) begin
            we_d   = 1'b1;
            addr_d = {row_q, col_q};
            din_d  = chr;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              adv_row = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (chr)
              8'h0D: col_d = '0;
              8'h0A: adv_row = 1'b1;
              8'h08: begin
                if (row_q != '0 || col_q != '0) begin
                  if (col_q == '0) begin
                    col_d = LAST_COL;
                    row_d = row_q - 1'b1;
                  end else begin
                    col_d = col_q - 1'b1;
                  end
                  we_d   = 1'b1;
                  addr_d = {row_d, col_d};
                  din_d  = BLANK_CHAR;
                end
              end
              8'h0C: begin
                row_d   = '0;
                col_d   = '0;
                fill_d  = '0;
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        we_d   = 1'b1;
        din_d  = BLANK_CHAR;
        addr_d = {row_q, fill_q[CW-1:0]};
        fill_d = fill_q + 1'b1;
        if (fill_q[CW-1:0] == LAST_COL) state_d = IDLE;
      end
      CLR_ALL: begin
        we_d   = 1'b1;
        din_d  = BLANK_CHAR;
        addr_d = fill_q;
        fill_d = fill_q + 1'b1;
        if (fill_q == LAST_CELL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Scrolling off the bottom wraps to the top row, which must be blanked first.
    if (adv_row) begin
      if (row_q == LAST_ROW) begin
        row_d   = '0;
        fill_d  = '0;
        state_d = CLR_LINE;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      fill_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      mw_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      fill_q     <= fill_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      mw_q       <= mem_write;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign vm_we       = we_q;
  assign vm_addr     = addr_q;
  assign vm_din      = din_q;
  assign cursor_addr = {row_q, col_q};
  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_tty_char_writer.sv
// Bench for tty_char_writer: a transaction-level console model predicts the ordered
// stream of VM writes and the cursor; directed cases pin exact timing and sticky flags.
module tb_tty_char_writer;

  localparam int COLS   = 32;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 10;

  logic              clk_50mhz = 1'b0;
  logic              rst_n     = 1'b0;
  logic [31:0]       bus_data  = '0;
  logic              mem_write = 1'b0;
  logic              vm_we;
  logic [ADDR_W-1:0] vm_addr;
  logic [7:0]        vm_din;
  logic [ADDR_W-1:0] cursor_addr;
  logic              busy;
  logic              overflow;

  tty_char_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK_CHAR(8'h20)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
    .bus_data   (bus_data),
    .mem_write  (mem_write),
    .vm_we      (vm_we),
    .vm_addr    (vm_addr),
    .vm_din     (vm_din),
    .cursor_addr(cursor_addr),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int total = 0;
  int bad   = 0;
  int expQ[$];
  int mRow = 0, mCol = 0;
  int weCount = 0, busyCount = 0, cyc = 0;
  int lastAddr = 0, lastDin = 0, lastWeCyc = 0, prevWeCyc = 0;
  int expWord;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWrite(input int addr, input int ch);
    expQ.push_back(addr * 256 + ch);
  endtask

  task automatic nextRow(output int fillLen);
    fillLen = 0;
    if (mRow == ROWS - 1) begin
      mRow = 0;
      for (int a = 0; a < COLS; a++) pushWrite(a, 32);
      fillLen = COLS;
    end else begin
      mRow++;
    end
  endtask

  // Console semantics on a linear position; produces the writes the byte must cause.
  task automatic modelByte(input int b, output int fillLen);
    int pos;
    fillLen = 0;
    if (b >= 32) begin
      pushWrite(mRow * COLS + mCol, b);
      mCol++;
      if (mCol == COLS) begin
        mCol = 0;
        nextRow(fillLen);
      end
    end else if (b == 13) begin
      mCol = 0;
    end else if (b == 10) begin
      nextRow(fillLen);
    end else if (b == 8) begin
      pos = mRow * COLS + mCol;
      if (pos > 0) begin
        pos--;
        mRow = pos / COLS;
        mCol = pos % COLS;
        pushWrite(pos, 32);
      end
    end else if (b == 12) begin
      mRow = 0;
      mCol = 0;
      for (int a = 0; a < ROWS * COLS; a++) pushWrite(a, 32);
      fillLen = ROWS * COLS;
    end
  endtask

  always @(negedge clk_50mhz) begin
    cyc++;
    if (rst_n) begin
      if (busy) busyCount++;
      if (vm_we) begin
        weCount++;
        prevWeCyc = lastWeCyc;
        lastWeCyc = cyc;
        lastAddr  = int'(vm_addr);
        lastDin   = int'(vm_din);
        if (expQ.size() == 0) begin
          checkOutput("unexpected vm write", int'({vm_addr, vm_din}), -1);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("vm write addr/data", int'({vm_addr, vm_din}), expWord);
        end
      end
    end
  end

  task automatic applyStimulus(input int b, input int hi, input bit modelled, output int fillLen);
    @(negedge clk_50mhz);
    bus_data       = $urandom();
    bus_data[7:0]  = b[7:0];
    mem_write      = 1'b1;
    fillLen        = 0;
    if (modelled) modelByte(b, fillLen);
    repeat (hi) @(negedge clk_50mhz);
    mem_write = 1'b0;
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(negedge clk_50mhz);
    checkOutput("write queue drained", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic sendByte(input int b);
    int fl;
    applyStimulus(b, $urandom_range(1, 5), 1'b1, fl);
    settle(fl + 4);
    checkOutput("cursor vs model", int'(cursor_addr), mRow * COLS + mCol);
  endtask

  task automatic doReset();
    @(negedge clk_50mhz);
    rst_n     = 1'b0;
    mem_write = 1'b0;
    expQ.delete();
    mRow = 0;
    mCol = 0;
    repeat (2) @(negedge clk_50mhz);
    rst_n = 1'b1;
  endtask

  initial begin
    int fl, w0, r;
    repeat (3) @(negedge clk_50mhz);
    checkOutput("reset vm_we", int'(vm_we), 0);
    checkOutput("reset vm_addr", int'(vm_addr), 0);
    checkOutput("reset vm_din", int'(vm_din), 0);
    checkOutput("reset cursor", int'(cursor_addr), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    rst_n = 1'b1;

    $display("[TB] single write, strobe held 3 cycles");
    w0 = weCount;
    @(negedge clk_50mhz);
    bus_data  = 32'hDEAD_BE41;
    mem_write = 1'b1;
    modelByte(8'h41, fl);
    @(negedge clk_50mhz);
    checkOutput("t1 vm_we", int'(vm_we), 1);
    checkOutput("t1 vm_addr", int'(vm_addr), 0);
    checkOutput("t1 vm_din", int'(vm_din), 8'h41);
    checkOutput("t1 cursor", int'(cursor_addr), 1);
    @(negedge clk_50mhz);
    checkOutput("t1 vm_we second cycle", int'(vm_we), 0);
    @(negedge clk_50mhz);
    mem_write = 1'b0;
    settle(4);
    checkOutput("t1 write count", weCount - w0, 1);

    $display("[TB] A B CR LF C");
    doReset();
    sendByte(8'h41); sendByte(8'h42); sendByte(8'h0D); sendByte(8'h0A); sendByte(8'h43);
    checkOutput("t2 cursor", int'(cursor_addr), 33);
    checkOutput("t2 last addr", lastAddr, 32);

    $display("[TB] end of row and backspace");
    doReset();
    for (int i = 0; i < 31; i++) sendByte($urandom_range(8'h20, 8'hFF));
    checkOutput("t3 cursor at 31", int'(cursor_addr), 31);
    sendByte(8'h5A);
    checkOutput("t3 cursor after wrap", int'(cursor_addr), 32);
    checkOutput("t3 wrap write addr", lastAddr, 31);
    sendByte(8'h08);
    checkOutput("t3 cursor after BS", int'(cursor_addr), 31);
    checkOutput("t3 BS addr", lastAddr, 31);
    checkOutput("t3 BS data", lastDin, 8'h20);

    $display("[TB] LF on bottom row clears row 0");
    doReset();
    for (int i = 0; i < 29; i++) sendByte(8'h0A);
    for (int i = 0; i < 5; i++) sendByte(8'h61 + i);
    checkOutput("t4 cursor row29 col5", int'(cursor_addr), 29 * 32 + 5);
    busyCount = 0;
    w0 = weCount;
    sendByte(8'h0A);
    checkOutput("t4 cursor", int'(cursor_addr), 5);
    checkOutput("t4 busy cycles", busyCount, 32);
    checkOutput("t4 fill writes", weCount - w0, 32);
    checkOutput("t4 last fill addr", lastAddr, 31);
    checkOutput("t4 busy after", int'(busy), 0);

    $display("[TB] form feed with pending and dropped bytes");
    w0 = weCount;
    applyStimulus(8'h0C, 2, 1'b1, fl);
    checkOutput("t5 busy during fill", int'(busy), 1);
    repeat (50) @(negedge clk_50mhz);
    applyStimulus(8'h58, 3, 1'b1, r);
    repeat (20) @(negedge clk_50mhz);
    applyStimulus(8'h59, 2, 1'b0, r);
    repeat (2) @(negedge clk_50mhz);
    checkOutput("t5 overflow set", int'(overflow), 1);
    settle(fl + 10);
    checkOutput("t5 write count", weCount - w0, 961);
    checkOutput("t5 pending addr", lastAddr, 0);
    checkOutput("t5 pending data", lastDin, 8'h58);
    checkOutput("t5 no gap after fill", lastWeCyc - prevWeCyc, 1);
    checkOutput("t5 cursor", int'(cursor_addr), 1);
    checkOutput("t5 overflow sticky", int'(overflow), 1);

    $display("[TB] reset in the middle of a screen clear");
    applyStimulus(8'h0C, 1, 1'b1, fl);
    repeat (100) @(negedge clk_50mhz);
    @(posedge clk_50mhz);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6 vm_we", int'(vm_we), 0);
    checkOutput("t6 vm_addr", int'(vm_addr), 0);
    checkOutput("t6 vm_din", int'(vm_din), 0);
    checkOutput("t6 cursor", int'(cursor_addr), 0);
    checkOutput("t6 busy", int'(busy), 0);
    checkOutput("t6 overflow", int'(overflow), 0);
    expQ.delete();
    mRow = 0;
    mCol = 0;
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    sendByte(8'h51);
    checkOutput("t6 Q addr", lastAddr, 0);
    checkOutput("t6 Q data", lastDin, 8'h51);

    $display("[TB] randomized byte stream");
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      sendByte($urandom_range(8'h20, 8'hFF));
      else if (r < 70) sendByte(8'h0A);
      else if (r < 78) sendByte(8'h0D);
      else if (r < 88) sendByte(8'h08);
      else if (r < 90) sendByte(8'h0C);
      else             sendByte($urandom_range(0, 31));
    end
    checkOutput("random overflow clear", int'(overflow), 0);
    checkOutput("random busy clear", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
